instr_cache: RTL and testbench

// Direct-mapped instruction cache between instruction fetch and memory_controller.
// - Serves 32-bit instructions to fetch.
// - On a miss, asks the memory controller for one aligned 8-byte line (two instructions) and fills it.
// - Drops any in-flight fetch when a misprediction clear arrives.

---
 rtl/instr_cache.sv | 179 +++++++++++++++++
 tb/tb_instr_cache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache: 2^INDEX_BITS lines of two 32-bit words, filled one line per miss.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module instr_cache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_signal,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        mem_signal,
  output logic [31:0] mem_a,
  input  logic [63:0] mem_d,
  input  logic        mem_done
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - 3;

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  state_e state_q, state_d;

  logic [63:0]      data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_data_q, instr_data_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        mem_signal_q, mem_signal_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic [INDEX_BITS-1:0] fetch_idx_c;
  logic [TAG_W-1:0]      fetch_tag_c;
  logic [INDEX_BITS-1:0] fill_idx_c;
  logic [TAG_W-1:0]      fill_tag_c;
  logic [63:0]           hit_line_c;
  logic                  hit_c;
  logic                  accept_c;
  logic                  fill_we_c;

  // Address split and tag lookup for the incoming fetch and the pending fill
  always_comb begin
    fetch_idx_c = fetch_pc[INDEX_BITS+2:3];
    fetch_tag_c = fetch_pc[31:INDEX_BITS+3];
    fill_idx_c  = req_pc_q[INDEX_BITS+2:3];
    fill_tag_c  = req_pc_q[31:INDEX_BITS+3];
    hit_line_c  = data_q[fetch_idx_c];
    hit_c       = valid_q[fetch_idx_c] && (tag_q[fetch_idx_c] == fetch_tag_c);
    accept_c    = (state_q == IDLE) && fetch_valid && !clear_signal && !instr_valid_q;
  end

  // Next-state and output register logic; instr_valid defaults low so it only ever pulses
  always_comb begin
    state_d       = state_q;
    instr_valid_d = 1'b0;
    instr_data_d  = instr_data_q;
    instr_pc_d    = instr_pc_q;
    mem_signal_d  = mem_signal_q;
    mem_a_d       = mem_a_q;
    req_pc_d      = req_pc_q;
    fill_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (hit_c) begin
            instr_valid_d = 1'b1;
            instr_data_d  = fetch_pc[2] ? hit_line_c[63:32] : hit_line_c[31:0];
            instr_pc_d    = fetch_pc;
          end else begin
            state_d      = FILL;
            mem_signal_d = 1'b1;
            mem_a_d      = {fetch_pc[31:3], 3'b000};
            req_pc_d     = fetch_pc;
          end
        end
      end
      FILL: begin
        if (mem_done) begin
          // A completed line is always kept, even when the fetch was flushed
          fill_we_c    = rdy_in;
          mem_signal_d = 1'b0;
          state_d      = IDLE;
          if (!clear_signal) begin
            instr_valid_d = 1'b1;
            instr_data_d  = req_pc_q[2] ? mem_d[63:32] : mem_d[31:0];
            instr_pc_d    = req_pc_q;
          end
        end else if (clear_signal) begin
          mem_signal_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        mem_signal_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      instr_valid_q <= 1'b0;
      instr_data_q  <= 32'h0;
      instr_pc_q    <= 32'h0;
      mem_signal_q  <= 1'b0;
      mem_a_q       <= 32'h0;
      req_pc_q      <= 32'h0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_data_q  <= instr_data_d;
      instr_pc_q    <= instr_pc_d;
      mem_signal_q  <= mem_signal_d;
      mem_a_q       <= mem_a_d;
      req_pc_q      <= req_pc_d;
    end
  end

  // Valid bits need reset; data and tag arrays do not
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (fill_we_c) begin
      valid_q[fill_idx_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we_c) begin
      data_q[fill_idx_c] <= mem_d;
      tag_q[fill_idx_c]  <= fill_tag_c;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_data  = instr_data_q;
  assign instr_pc    = instr_pc_q;
  assign mem_signal  = mem_signal_q;
  assign mem_a       = mem_a_q;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Counts accepted requests by outcome; a later flush does not undo a miss
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else if (rdy_in && accept_c) begin
      if (hit_c) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: stimulus queues expected {data,pc}, a negedge monitor checks pulses.
module tb_instr_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_signal;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        mem_signal;
  logic [31:0] mem_a;
  logic [63:0] mem_d;
  logic        mem_done;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  instr_cache #(.INDEX_BITS(6)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear_signal (clear_signal),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .mem_signal   (mem_signal),
    .mem_a        (mem_a),
    .mem_d        (mem_d),
    .mem_done     (mem_done)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every instr_valid pulse must match the oldest queued expectation
  always @(negedge clk_in) begin
    if (!rst_in && instr_valid === 1'b1) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pc %h data %h expected no pulse", instr_pc, instr_data);
      end else begin
        e = exp_q.pop_front();
        check("pulse_data", instr_data, e[63:32]);
        check("pulse_pc", instr_pc, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_hit(input logic [31:0] pc, input logic [31:0] exp_word);
    exp_q.push_back({exp_word, pc});
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
    check("hit_pulse", 32'(instr_valid), 32'd1);
    check("hit_no_mem", 32'(mem_signal), 32'd0);
    tick();
    check("hit_fall", 32'(instr_valid), 32'd0);
  endtask

  // mode 0: normal fill, 1: clear before done, 2: clear with done, 3: freeze with done pending
  task automatic do_miss(input logic [31:0] pc, input logic [31:0] line_a, input logic [63:0] line,
                         input logic [31:0] exp_word, input int mode);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    tick();
    fetch_valid = 1'b0;
    check("miss_req", 32'(mem_signal), 32'd1);
    check("miss_addr", mem_a, line_a);
    check("miss_no_pulse", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("fill_hold_sig", 32'(mem_signal), 32'd1);
      check("fill_hold_addr", mem_a, line_a);
    end
    mem_d = line;
    case (mode)
      1: clear_signal = 1'b1;
      2: begin clear_signal = 1'b1; mem_done = 1'b1; end
      3: begin
        mem_done = 1'b1;
        rdy_in   = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          check("frz_sig", 32'(mem_signal), 32'd1);
          check("frz_addr", mem_a, line_a);
          check("frz_valid", 32'(instr_valid), 32'd0);
        end
        rdy_in = 1'b1;
      end
      default: mem_done = 1'b1;
    endcase
    if (mode == 0 || mode == 3) exp_q.push_back({exp_word, pc});
    tick();
    mem_done     = 1'b0;
    clear_signal = 1'b0;
    check("fill_end_sig", 32'(mem_signal), 32'd0);
    check("fill_end_valid", 32'(instr_valid), (mode == 0 || mode == 3) ? 32'd1 : 32'd0);
    tick();
    check("fill_fall", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    clear_signal = 1'b0;
    fetch_valid  = 1'b0;
    fetch_pc     = 32'h0;
    mem_d        = 64'h0;
    mem_done     = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_sig", 32'(mem_signal), 32'd0);
    check("rst_addr", mem_a, 32'h0);
    rst_in = 1'b0;
    tick();

    do_miss(32'h0, 32'h0, 64'h00100093_00000013, 32'h00000013, 0);
    do_hit(32'h4, 32'h00100093);
    do_miss(32'h200, 32'h200, 64'hAAAA0001_BBBB0002, 32'hBBBB0002, 0);
    do_miss(32'h0, 32'h0, 64'h00100093_00000013, 32'h00000013, 0);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_a", hit_cnt, 32'd1);
    check("perf_miss_a", miss_cnt, 32'd3);
`endif

    do_miss(32'h48, 32'h48, 64'h99999999_88888888, 32'h0, 1);
    do_miss(32'h48, 32'h48, 64'h11112222_33334444, 32'h0, 2);
    do_hit(32'h48, 32'h33334444);
    do_hit(32'h4C, 32'h11112222);

    do_miss(32'h1004, 32'h1000, 64'hCAFEF00D_DEADBEEF, 32'hCAFEF00D, 3);
    do_hit(32'h1000, 32'hDEADBEEF);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_b", hit_cnt, 32'd4);
    check("perf_miss_b", miss_cnt, 32'd6);
`endif

    // Reset during a fill
    fetch_valid = 1'b1;
    fetch_pc    = 32'h80;
    tick();
    fetch_valid = 1'b0;
    check("pre_rst_sig", 32'(mem_signal), 32'd1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_sig", 32'(mem_signal), 32'd0);
    check("mid_rst_addr", mem_a, 32'h0);
    check("mid_rst_data", instr_data, 32'h0);
    check("mid_rst_pc", instr_pc, 32'h0);
    tick();
    rst_in = 1'b0;
    tick();
    do_miss(32'h0, 32'h0, 64'h00100093_00000013, 32'h00000013, 0);
    do_hit(32'h4, 32'h00100093);
`ifdef ICACHE_PERF_CNT_EN
    check("perf_hit_c", hit_cnt, 32'd1);
    check("perf_miss_c", miss_cnt, 32'd1);
`endif

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
